// File: rtl/multdiv.sv
// Signed multiply / divide unit. It performs one iteration per clock.
// A multiply is shift-add on operand magnitudes. A divide is restoring
// division on magnitudes. The sign of the answer is applied when the
// operation finishes.
//
// state  | meaning
// IDLE   | waiting for a start pulse
// MUL    | shift-add iterations running
// DIV    | restoring-division iterations running
// DONE   | result valid, data_resultRDY strobe cycle
module multdiv #(
    parameter int WIDTH = 32
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [WIDTH-1:0] data_operandA,
    input  logic [WIDTH-1:0] data_operandB,
    input  logic             ctrl_MULT,
    input  logic             ctrl_DIV,
    output logic [WIDTH-1:0] data_result,
    output logic             data_exception,
    output logic             data_resultRDY,
    output logic             busy
);

    localparam int CW = $clog2(WIDTH) + 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_MUL,
        S_DIV,
        S_DONE
    } state_t;

    state_t              r_state;
    state_t              w_state_next;
    logic [CW-1:0]       r_count;
    logic [2*WIDTH-1:0]  r_acc;      // MUL: {partial hi, multiplier}; DIV: {remainder, quotient}
    logic [WIDTH-1:0]    r_opnd;     // MUL: |A| multiplicand; DIV: |B| divisor
    logic                r_neg;
    logic [WIDTH-1:0]    r_result;
    logic                r_exc;

    logic                w_start;
    logic                w_last;
    logic [WIDTH-1:0]    w_mag_a;
    logic [WIDTH-1:0]    w_mag_b;
    logic [WIDTH:0]      w_add;
    logic [WIDTH:0]      w_sum;
    logic [2*WIDTH-1:0]  w_mul_next;
    logic [WIDTH:0]      w_shift;
    logic [WIDTH:0]      w_diff;
    logic [2*WIDTH-1:0]  w_div_next;
    logic [2*WIDTH-1:0]  w_prod;
    logic                w_mul_ovf;
    logic [WIDTH-1:0]    w_quot;

    assign w_start = ctrl_MULT | ctrl_DIV;
    assign w_last  = (r_count == CW'(WIDTH));
    assign w_mag_a = data_operandA[WIDTH-1] ? -data_operandA : data_operandA;
    assign w_mag_b = data_operandB[WIDTH-1] ? -data_operandB : data_operandB;

    // One shift-add step: conditionally add the multiplicand into the high half, then shift right.
    assign w_add      = r_acc[0] ? {1'b0, r_opnd} : '0;
    assign w_sum      = {1'b0, r_acc[2*WIDTH-1:WIDTH]} + w_add;
    assign w_mul_next = {w_sum, r_acc[WIDTH-1:1]};

    // One restoring step. The borrow out of w_diff decides whether the divisor fits.
    // The remainder stays below the divisor, so bit WIDTH of w_diff is a clean borrow.
    assign w_shift    = {r_acc[2*WIDTH-1:WIDTH], r_acc[WIDTH-1]};
    assign w_diff     = w_shift - {1'b0, r_opnd};
    assign w_div_next = w_diff[WIDTH] ? {w_shift[WIDTH-1:0], r_acc[WIDTH-2:0], 1'b0}
                                      : {w_diff[WIDTH-1:0],  r_acc[WIDTH-2:0], 1'b1};

    // Apply the final sign. A product fits in WIDTH bits only if its top WIDTH+1 bits agree.
    assign w_prod    = r_neg ? -r_acc : r_acc;
    assign w_mul_ovf = !((&w_prod[2*WIDTH-1:WIDTH-1]) || !(|w_prod[2*WIDTH-1:WIDTH-1]));
    assign w_quot    = r_neg ? -r_acc[WIDTH-1:0] : r_acc[WIDTH-1:0];

    // State register
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state logic. A start in any state wins; multiply wins when both starts are high.
    always_comb begin
        w_state_next = r_state;
        if (w_start) begin
            w_state_next = ctrl_MULT ? S_MUL : S_DIV;
        end else begin
            case (r_state)
                S_MUL, S_DIV: if (w_last) w_state_next = S_DONE;
                S_DONE:       w_state_next = S_IDLE;
                default:      w_state_next = r_state;
            endcase
        end
    end

    // Datapath: latch operands on start, iterate WIDTH times, then finalize into the result registers.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_count  <= '0;
            r_acc    <= '0;
            r_opnd   <= '0;
            r_neg    <= 1'b0;
            r_result <= '0;
            r_exc    <= 1'b0;
        end else if (w_start) begin
            r_count <= '0;
            r_neg   <= data_operandA[WIDTH-1] ^ data_operandB[WIDTH-1];
            if (ctrl_MULT) begin
                r_acc  <= {{WIDTH{1'b0}}, w_mag_b};
                r_opnd <= w_mag_a;
            end else begin
                r_acc  <= {{WIDTH{1'b0}}, w_mag_a};
                r_opnd <= w_mag_b;
            end
        end else if (r_state == S_MUL) begin
            if (w_last) begin
                r_result <= w_prod[WIDTH-1:0];
                r_exc    <= w_mul_ovf;
            end else begin
                r_acc   <= w_mul_next;
                r_count <= r_count + CW'(1);
            end
        end else if (r_state == S_DIV) begin
            if (w_last) begin
                if (r_opnd == '0) begin
                    r_result <= '0;
                    r_exc    <= 1'b1;
                end else begin
                    // A positive quotient with magnitude 2^(WIDTH-1) only arises from MIN / -1.
                    r_result <= w_quot;
                    r_exc    <= ~r_neg & r_acc[WIDTH-1];
                end
            end else begin
                r_acc   <= w_div_next;
                r_count <= r_count + CW'(1);
            end
        end
    end

    assign data_result    = r_result;
    assign data_exception = r_exc;
    assign data_resultRDY = (r_state == S_DONE);
    assign busy           = (r_state == S_MUL) || (r_state == S_DIV);

endmodule

// File: tb/tb_multdiv.sv
// Directed bench for multdiv: a vector table plus abort and reset sequences.
module tb_multdiv;

    logic        clock = 1'b0;
    logic        reset;
    logic [31:0] data_operandA;
    logic [31:0] data_operandB;
    logic        ctrl_MULT;
    logic        ctrl_DIV;
    logic [31:0] data_result;
    logic        data_exception;
    logic        data_resultRDY;
    logic        busy;

    multdiv #(.WIDTH(32)) dut (
        .clock          (clock),
        .reset          (reset),
        .data_operandA  (data_operandA),
        .data_operandB  (data_operandB),
        .ctrl_MULT      (ctrl_MULT),
        .ctrl_DIV       (ctrl_DIV),
        .data_result    (data_result),
        .data_exception (data_exception),
        .data_resultRDY (data_resultRDY),
        .busy           (busy)
    );

    always #5 clock = ~clock;

    int n_pass  = 0;
    int n_total = 0;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic        mul;
        logic        div;
        logic [31:0] res;
        logic        exc;
    } vec_t;

    vec_t vecs[14];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    // Present operands and start pulses for one rising edge (the start edge).
    // Afterwards, scramble the operands so that any late sampling shows up.
    task automatic start_op(input logic [31:0] a, input logic [31:0] b, input logic m, input logic d);
        @(negedge clock);
        data_operandA = a;
        data_operandB = b;
        ctrl_MULT     = m;
        ctrl_DIV      = d;
        @(posedge clock);
        #1;
        ctrl_MULT     = 1'b0;
        ctrl_DIV      = 1'b0;
        data_operandA = 32'hA5A5_5A5A;
        data_operandB = 32'h0F0F_F0F0;
    endtask

    // Step ncyc edges and sample each one. Record the first strobe and count all strobes.
    task automatic watch(input int ncyc, output int lat, output int nstrobe,
                         output logic [31:0] res, output logic exc,
                         output logic busy1, output logic busy_rdy);
        lat = -1; nstrobe = 0; res = '0; exc = 1'b0; busy1 = 1'b0; busy_rdy = 1'b1;
        for (int k = 1; k <= ncyc; k++) begin
            @(posedge clock);
            #1;
            if (k == 1) busy1 = busy;
            if (data_resultRDY) begin
                nstrobe++;
                if (lat < 0) begin
                    lat      = k;
                    res      = data_result;
                    exc      = data_exception;
                    busy_rdy = busy;
                end
            end
        end
    endtask

    initial begin
        int          lat, ns;
        logic [31:0] res;
        logic        exc, b1, brdy;

        vecs[0]  = '{32'd6,         32'd7,         1'b1, 1'b0, 32'd42,        1'b0};
        vecs[1]  = '{32'hFFFFFFFD, 32'd5,         1'b1, 1'b0, 32'hFFFFFFF1, 1'b0};
        vecs[2]  = '{32'h00010000, 32'h00010000, 1'b1, 1'b0, 32'h00000000, 1'b1};
        vecs[3]  = '{32'h7FFFFFFF, 32'hFFFFFFFF, 1'b1, 1'b0, 32'h80000001, 1'b0};
        vecs[4]  = '{32'd100,       32'd7,         1'b0, 1'b1, 32'd14,        1'b0};
        vecs[5]  = '{32'hFFFFFFF9, 32'd2,         1'b0, 1'b1, 32'hFFFFFFFD, 1'b0};
        vecs[6]  = '{32'd5,         32'd0,         1'b0, 1'b1, 32'd0,         1'b1};
        vecs[7]  = '{32'h80000000, 32'hFFFFFFFF, 1'b0, 1'b1, 32'h80000000, 1'b1};
        vecs[8]  = '{32'd2,         32'd3,         1'b1, 1'b1, 32'd6,         1'b0};
        vecs[9]  = '{32'h80000000, 32'hFFFFFFFF, 1'b1, 1'b0, 32'h80000000, 1'b1};
        vecs[10] = '{32'hFFFFFFFA, 32'hFFFFFFFD, 1'b0, 1'b1, 32'd2,         1'b0};
        vecs[11] = '{32'd7,         32'hFFFFFFFE, 1'b0, 1'b1, 32'hFFFFFFFD, 1'b0};
        vecs[12] = '{32'h80000000, 32'd1,         1'b1, 1'b0, 32'h80000000, 1'b0};
        vecs[13] = '{32'h80000000, 32'd1,         1'b0, 1'b1, 32'h80000000, 1'b0};

        reset = 1'b1; ctrl_MULT = 1'b0; ctrl_DIV = 1'b0;
        data_operandA = '0; data_operandB = '0;
        repeat (2) @(posedge clock);
        #1;
        check("reset result", data_result, 32'd0);
        check("reset exc",    {31'd0, data_exception}, 32'd0);
        check("reset rdy",    {31'd0, data_resultRDY}, 32'd0);
        check("reset busy",   {31'd0, busy}, 32'd0);
        @(negedge clock);
        reset = 1'b0;

        for (int i = 0; i < 14; i++) begin
            start_op(vecs[i].a, vecs[i].b, vecs[i].mul, vecs[i].div);
            watch(36, lat, ns, res, exc, b1, brdy);
            check($sformatf("v%0d latency", i), 32'(lat), 32'd33);
            check($sformatf("v%0d strobes", i), 32'(ns), 32'd1);
            check($sformatf("v%0d result", i), res, vecs[i].res);
            check($sformatf("v%0d exc", i), {31'd0, exc}, {31'd0, vecs[i].exc});
            check($sformatf("v%0d busy", i), {31'd0, b1}, 32'd1);
            check($sformatf("v%0d busy at rdy", i), {31'd0, brdy}, 32'd0);
            check($sformatf("v%0d hold", i), data_result, vecs[i].res);
        end

        // A divide started 10 cycles into a multiply aborts the multiply without a strobe.
        start_op(32'd6, 32'd7, 1'b1, 1'b0);
        watch(9, lat, ns, res, exc, b1, brdy);
        check("abort pre strobes", 32'(ns), 32'd0);
        start_op(32'd9, 32'd3, 1'b0, 1'b1);
        watch(36, lat, ns, res, exc, b1, brdy);
        check("abort latency", 32'(lat), 32'd33);
        check("abort strobes", 32'(ns), 32'd1);
        check("abort result", res, 32'd3);
        check("abort exc", {31'd0, exc}, 32'd0);

        // Reset 15 cycles into a divide clears the outputs, and no strobe follows.
        start_op(32'd100, 32'd7, 1'b0, 1'b1);
        watch(14, lat, ns, res, exc, b1, brdy);
        check("rst pre strobes", 32'(ns), 32'd0);
        @(negedge clock);
        reset = 1'b1;
        @(posedge clock);
        #1;
        check("rst result", data_result, 32'd0);
        check("rst exc",    {31'd0, data_exception}, 32'd0);
        check("rst rdy",    {31'd0, data_resultRDY}, 32'd0);
        check("rst busy",   {31'd0, busy}, 32'd0);
        @(negedge clock);
        reset = 1'b0;
        watch(40, lat, ns, res, exc, b1, brdy);
        check("rst post strobes", 32'(ns), 32'd0);
        start_op(32'd2, 32'd3, 1'b1, 1'b1);
        watch(36, lat, ns, res, exc, b1, brdy);
        check("rst restart latency", 32'(lat), 32'd33);
        check("rst restart result", res, 32'd6);
        check("rst restart exc", {31'd0, exc}, 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
